// File: rtl/ser_pkg.sv
// Shared types and defaults for the bit_serializer block.
package ser_pkg;

  // Two-state serializer FSM: waiting for a word, or shifting one out.
  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

  localparam int   SER_WIDTH_DEFAULT      = 8;
  localparam logic SER_IDLE_LEVEL_DEFAULT = 1'b0;

endpackage

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bus of the bit_serializer.
// master = word producer and bit consumer, slave = the serializer.
interface bit_serializer_if #(
  parameter int WIDTH = ser_pkg::SER_WIDTH_DEFAULT
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             bit_en;
  logic             bit_out;
  logic             bit_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output in_data, in_valid, bit_en,
    input  in_ready, bit_out, bit_valid, word_done, busy
  );

  modport slave (
    input  in_data, in_valid, bit_en,
    output in_ready, bit_out, bit_valid, word_done, busy
  );
endinterface

// File: rtl/ser_hold_buf.sv
// One-entry holding register (valid flag + data) with load/pop strobes.
// The owner never loads while full and never pops while empty.
module ser_hold_buf #(
  parameter int WIDTH = ser_pkg::SER_WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  logic             full_q;
  logic [WIDTH-1:0] data_q;

  // Capture a word on load, release it on pop; reset empties the entry.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      if (pop_i) begin
        full_q <= 1'b0;
      end
      if (load_i) begin
        full_q <= 1'b1;
        data_q <= data_i;
      end
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready
// and shifts them out MSB-first, one bit per posedge with bit_en=1.
// Optional macro SER_PREFETCH_EN adds a one-word holding buffer so that
// consecutive words stream without an idle gap.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int   WIDTH      = SER_WIDTH_DEFAULT,
  parameter logic IDLE_LEVEL = SER_IDLE_LEVEL_DEFAULT
) (
  input logic             clock,
  input logic             reset_n,
  bit_serializer_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;

  logic             in_ready;
  logic             xfer;
  logic             last_bit;

`ifdef SER_PREFETCH_EN
  logic             buf_full;
  logic [WIDTH-1:0] buf_data;
  logic             buf_load;
  logic             buf_pop;

  ser_hold_buf #(.WIDTH(WIDTH)) u_hold_buf (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .load_i (buf_load),
    .data_i (bus.in_data),
    .pop_i  (buf_pop),
    .full_o (buf_full),
    .data_o (buf_data)
  );

  // The buffer is the only thing that can refuse a word.
  assign in_ready = !buf_full && reset_n;
  assign bus.busy = (state_q == SER_SHIFT) || buf_full;
`else
  assign in_ready = (state_q == SER_IDLE) && reset_n;
  assign bus.busy = (state_q == SER_SHIFT);
`endif

  assign xfer     = bus.in_valid && in_ready;
  assign last_bit = (state_q == SER_SHIFT) && bus.bit_en && (cnt_q == '0);

  // Next-state: word load, shift/hold, and end-of-word reload or return to IDLE.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef SER_PREFETCH_EN
    buf_pop  = 1'b0;
    // Mid-word arrivals park in the buffer; at the last bit an empty buffer is bypassed.
    buf_load = xfer && (state_q == SER_SHIFT) && !last_bit;
`endif
    unique case (state_q)
      SER_IDLE: begin
        if (xfer) begin
          sreg_d  = bus.in_data;
          cnt_d   = CW'(WIDTH - 1);
          state_d = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        if (bus.bit_en) begin
          if (cnt_q != '0) begin
            sreg_d = sreg_q << 1;
            cnt_d  = cnt_q - CW'(1);
          end else begin
            done_d = 1'b1;
`ifdef SER_PREFETCH_EN
            if (buf_full) begin
              sreg_d  = buf_data;
              cnt_d   = CW'(WIDTH - 1);
              buf_pop = 1'b1;
            end else if (xfer) begin
              sreg_d = bus.in_data;
              cnt_d  = CW'(WIDTH - 1);
            end else begin
              state_d = SER_IDLE;
            end
`else
            state_d = SER_IDLE;
`endif
          end
        end
      end
      default: state_d = SER_IDLE;
    endcase
    // Serial outputs are registered copies of what the next state presents.
    bit_valid_d = (state_d == SER_SHIFT);
    bit_out_d   = (state_d == SER_SHIFT) ? sreg_d[WIDTH-1] : IDLE_LEVEL;
  end

  // State, datapath and output registers; reset aborts any word in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= SER_IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      bit_out_q   <= IDLE_LEVEL;
      bit_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.bit_out   = bit_out_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.word_done = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer (WIDTH=8, IDLE_LEVEL=0).
// Directed table vectors, hand-written corner sequences and a randomized
// run scored against a word/bit queue model.
module tb_bit_serializer;

  localparam int   W  = 8;
  localparam logic IL = 1'b0;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  bit_serializer_if #(.WIDTH(W)) bus ();

  bit_serializer #(.WIDTH(W), .IDLE_LEVEL(IL)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] exp_bits;
    int           done_cyc;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // One word with bit_en held high, checked cycle by cycle.
  task automatic run_vec(input vec_t v);
    bus.in_data  = v.data;
    bus.in_valid = 1'b1;
    bus.bit_en   = 1'b1;
    chk("rdy_idle", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    for (int c = 1; c <= v.done_cyc; c++) begin
      if (c < v.done_cyc) begin
        chk("vec_bit", bus.bit_out, v.exp_bits[W-c]);
        chk("vec_bvld", bus.bit_valid, 1);
        chk("vec_done_lo", bus.word_done, 0);
        chk("vec_busy", bus.busy, 1);
      end else begin
        chk("vec_done", bus.word_done, 1);
        chk("vec_bvld_end", bus.bit_valid, 0);
        chk("vec_idle_lvl", bus.bit_out, IL);
        chk("vec_rdy_end", bus.in_ready, 1);
        chk("vec_busy_end", bus.busy, 0);
      end
      step();
    end
    chk("vec_done_1cyc", bus.word_done, 0);
  endtask

  initial begin
    logic [W-1:0] q_words[$];
    bit           expq[$];
    bit           exp_done;
    bit           hold;
    int           consumed;
    logic         hb_bits [1:11];
    logic         hb_en   [1:11];

    vt[0] = '{data: 8'hA5, exp_bits: 8'b1010_0101, done_cyc: 9};
    vt[1] = '{data: 8'hFF, exp_bits: 8'b1111_1111, done_cyc: 9};
    vt[2] = '{data: 8'h00, exp_bits: 8'b0000_0000, done_cyc: 9};
    vt[3] = '{data: 8'h81, exp_bits: 8'b1000_0001, done_cyc: 9};
    vt[4] = '{data: 8'h5A, exp_bits: 8'b0101_1010, done_cyc: 9};

    // Reset state
    reset_n      = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b1;
    bus.bit_en   = 1'b0;
    step();
    step();
    chk("rst_bit_out", bus.bit_out, IL);
    chk("rst_bvld", bus.bit_valid, 0);
    chk("rst_done", bus.word_done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rdy", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    chk("rdy_after_rst", bus.in_ready, 1);
    step();

    // Table vectors, bit_en held high
    for (int i = 0; i < 5; i++) begin
      run_vec(vt[i]);
    end

    // Stall: bit_en low for three cycles after bit 2 of 8'hA5
    hb_bits = '{1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1};
    hb_en   = '{1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    bus.in_data  = 8'hA5;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      bus.bit_en = hb_en[c];
      chk("stall_bit", bus.bit_out, hb_bits[c]);
      chk("stall_bvld", bus.bit_valid, 1);
      chk("stall_done_lo", bus.word_done, 0);
      step();
    end
    chk("stall_done", bus.word_done, 1);
    chk("stall_bvld_end", bus.bit_valid, 0);
    step();
    chk("stall_done_1cyc", bus.word_done, 0);

    // Reset during bit 4 of 8'hFF aborts the word
    bus.in_data  = 8'hFF;
    bus.in_valid = 1'b1;
    bus.bit_en   = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    step();
    chk("abort_pre_bit", bus.bit_out, 1);
    reset_n = 1'b0;
    step();
    chk("abort_bit_out", bus.bit_out, IL);
    chk("abort_bvld", bus.bit_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_rdy", bus.in_ready, 0);
    chk("abort_done", bus.word_done, 0);
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("abort_no_done", bus.word_done, 0);
      chk("abort_no_bvld", bus.bit_valid, 0);
    end
    run_vec(vt[0]);

`ifdef SER_PREFETCH_EN
    // Back-to-back 8'hF0, 8'h0F: 16 contiguous bits, done at +9 and +17
    bus.bit_en   = 1'b1;
    bus.in_data  = 8'hF0;
    bus.in_valid = 1'b1;
    step();
    for (int c = 1; c <= 17; c++) begin
      logic [W-1:0] wa, wb;
      wa = 8'hF0;
      wb = 8'h0F;
      if (c == 1) begin
        bus.in_data = 8'h0F;
      end else begin
        bus.in_valid = 1'b0;
      end
      chk("b2b_bvld", bus.bit_valid, (c <= 16) ? 1 : 0);
      if (c <= 8) chk("b2b_bit", bus.bit_out, wa[8-c]);
      else if (c <= 16) chk("b2b_bit", bus.bit_out, wb[16-c]);
      chk("b2b_done", bus.word_done, (c == 9 || c == 17) ? 1 : 0);
      step();
    end

    // Buffer full with in_valid held: third word waits, nothing lost
    bus.in_data  = 8'hC3;
    bus.in_valid = 1'b1;
    step();
    for (int c = 1; c <= 25; c++) begin
      logic [W-1:0] w;
      if (c == 1) bus.in_data = 8'h3C;
      else if (c <= 9) bus.in_data = 8'h99;
      if (c == 10) bus.in_valid = 1'b0;
      if (c >= 2 && c <= 9) chk("full_rdy", bus.in_ready, (c == 9) ? 1 : 0);
      w = (c <= 8) ? 8'hC3 : (c <= 16) ? 8'h3C : 8'h99;
      if (c <= 24) begin
        chk("full_bvld", bus.bit_valid, 1);
        chk("full_bit", bus.bit_out, w[W - 1 - ((c - 1) % W)]);
      end
      chk("full_done", bus.word_done, (c == 9 || c == 17 || c == 25) ? 1 : 0);
      step();
    end
`endif

    // Randomized traffic against a bit-queue model
    exp_done = 1'b0;
    hold     = 1'b0;
    consumed = 0;
    bus.in_valid = 1'b0;
    step();
    for (int cyc = 0; cyc < 3060; cyc++) begin
      bit drain;
      drain = (cyc >= 3000);
      chk("rnd_done", bus.word_done, exp_done);
      if (!hold) begin
        bus.in_valid = drain ? 1'b0 : ($urandom_range(0, 2) != 0);
        bus.in_data  = W'($urandom);
      end
      bus.bit_en = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
      #4;
      if (!bus.bit_valid) chk("rnd_idle_lvl", bus.bit_out, IL);
      chk("rnd_busy", bus.busy, (expq.size() != 0) ? 1 : 0);
`ifndef SER_PREFETCH_EN
      chk("rnd_rdy", bus.in_ready, !bus.bit_valid);
`endif
      exp_done = 1'b0;
      if (bus.bit_valid && bus.bit_en) begin
        if (expq.size() == 0) begin
          chk("rnd_unexpected_bit", 1, 0);
        end else begin
          chk("rnd_bit", bus.bit_out, expq.pop_front());
          consumed++;
          if (consumed % W == 0) exp_done = 1'b1;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q_words.push_back(bus.in_data);
        for (int b = W - 1; b >= 0; b--) expq.push_back(bus.in_data[b]);
        hold = 1'b0;
      end else begin
        hold = bus.in_valid;
      end
      step();
    end
    chk("rnd_drained", expq.size(), 0);
    chk("rnd_words", consumed, q_words.size() * W);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
